// File: rtl/timer_pkg.sv
// Shared constants and helpers for the multi-channel hold-time timer.
// Layer-timing defaults match the CNN sequencer delays they replace.
package timer_pkg;

  localparam int CNT_W_DEF = 12;

  localparam int T_CONV1 = 38;
  localparam int T_POOL1 = 15;
  localparam int T_CONV2 = 1;
  localparam int T_FC    = 285;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_COUNT,
    CH_DONE
  } ch_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/multi_channel_timer_if.sv
// Channel enables, status outputs and threshold-config port
// of the multi-channel timer.
interface multi_channel_timer_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 12
);
  import timer_pkg::*;

  localparam int CH_W = ch_w(NUM_CH);

  logic [NUM_CH-1:0] ti_i;
  logic [NUM_CH-1:0] to_o;
  logic [NUM_CH-1:0] done_pulse_o;
  logic [NUM_CH-1:0] sticky_o;
  logic [NUM_CH-1:0] sticky_clr_i;
  logic              cfg_we_i;
  logic [CH_W-1:0]   cfg_ch_i;
  logic [CNT_W-1:0]  cfg_thr_i;

  modport master (
    output ti_i,
    output sticky_clr_i,
    output cfg_we_i,
    output cfg_ch_i,
    output cfg_thr_i,
    input  to_o,
    input  done_pulse_o,
    input  sticky_o
  );

  modport slave (
    input  ti_i,
    input  sticky_clr_i,
    input  cfg_we_i,
    input  cfg_ch_i,
    input  cfg_thr_i,
    output to_o,
    output done_pulse_o,
    output sticky_o
  );

endinterface

// File: rtl/timer_channel.sv
// One timer channel: saturating hold counter, programmable threshold,
// edge-detect flop for the done pulse and a sticky status bit.
module timer_channel
  import timer_pkg::*;
#(
  parameter int               CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] THR_RST = CNT_W'(T_CONV1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ti,
  input  logic             thr_we,
  input  logic [CNT_W-1:0] thr_wdata,
  output logic             to,
  output logic             done_pulse,
  output logic             sticky,
  input  logic             sticky_clr
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] thr_q, thr_d;
  logic             to_q, to_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] thr_eff;
  logic             pulse;
  ch_state_e        st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      thr_q    <= THR_RST;
      to_q     <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      thr_q    <= thr_d;
      to_q     <= to_d;
      sticky_q <= sticky_d;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    thr_d    = thr_q;
    st       = CH_IDLE;
    thr_eff  = (thr_q == '0) ? CNT_W'(1) : thr_q;

    if (!ti) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (thr_we) begin
      thr_d = thr_wdata;
    end

    // thr_eff >= 1, so an idle counter can never be in DONE
    unique case (1'b1)
      (cnt_q == '0):      st = CH_IDLE;
      (cnt_q >= thr_eff): st = CH_DONE;
      default:            st = CH_COUNT;
    endcase

    to_d     = (st == CH_DONE);
    pulse    = to_d & ~to_q;
    sticky_d = pulse | (sticky_q & ~sticky_clr);
  end

  assign to         = to_d;
  assign done_pulse = pulse;
  assign sticky     = sticky_q;

endmodule

// File: rtl/multi_channel_timer.sv
// N-channel hold-time timer with runtime thresholds; channels are
// independent apart from the shared threshold-write port.
module multi_channel_timer
  import timer_pkg::*;
#(
  parameter int                        NUM_CH = 4,
  parameter int                        CNT_W  = CNT_W_DEF,
  parameter logic [NUM_CH*CNT_W-1:0]   THRESH_DEFAULT = {
    12'(T_FC), 12'(T_CONV2), 12'(T_POOL1), 12'(T_CONV1)
  }
) (
  input  logic                  S_AXIS_ACLK,
  input  logic                  S_AXIS_ARESET,
  multi_channel_timer_if.slave  bus
);

  localparam int CH_W = ch_w(NUM_CH);

  logic [NUM_CH-1:0] we_oh;

  // Channel numbers beyond NUM_CH match no slot, so the write is dropped
  always_comb begin
    we_oh = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.cfg_we_i && (bus.cfg_ch_i == CH_W'(i))) begin
        we_oh[i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    timer_channel #(
      .CNT_W   (CNT_W),
      .THR_RST (THRESH_DEFAULT[g*CNT_W +: CNT_W])
    ) u_ch (
      .clk        (S_AXIS_ACLK),
      .rst        (S_AXIS_ARESET),
      .ti         (bus.ti_i[g]),
      .thr_we     (we_oh[g]),
      .thr_wdata  (bus.cfg_thr_i),
      .to         (bus.to_o[g]),
      .done_pulse (bus.done_pulse_o[g]),
      .sticky     (bus.sticky_o[g]),
      .sticky_clr (bus.sticky_clr_i[g])
    );
  end

endmodule

// File: tb/tb_multi_channel_timer.sv
// Bench for multi_channel_timer: vector table, corner sequences,
// random traffic against a run-length reference model.
module tb_multi_channel_timer;

  localparam int MAXC = 4095;

  logic clk;
  logic rst;

  multi_channel_timer_if #(.NUM_CH(4), .CNT_W(12)) bus ();
  multi_channel_timer_if #(.NUM_CH(3), .CNT_W(4))  bus2 ();

  multi_channel_timer u_dut (
    .S_AXIS_ACLK   (clk),
    .S_AXIS_ARESET (rst),
    .bus           (bus)
  );

  multi_channel_timer #(
    .NUM_CH         (3),
    .CNT_W          (4),
    .THRESH_DEFAULT ({4'd2, 4'd9, 4'd15})
  ) u_dut2 (
    .S_AXIS_ACLK   (clk),
    .S_AXIS_ARESET (rst),
    .bus           (bus2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests;
  int fails;

  int run_m [4];
  int thr_m [4];
  bit to_prev [4];
  bit stk_m [4];
  int dflt [4] = '{38, 15, 1, 285};

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic bit m_to(input int i);
    int te;
    te = (thr_m[i] == 0) ? 1 : thr_m[i];
    return run_m[i] >= te;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      run_m[i]   = 0;
      thr_m[i]   = dflt[i];
      to_prev[i] = 0;
      stk_m[i]   = 0;
    end
  endtask

  task automatic model_edge();
    bit t;
    bit p;
    for (int i = 0; i < 4; i++) begin
      t = m_to(i);
      p = t & ~to_prev[i];
      stk_m[i]   = p | (stk_m[i] & ~bus.sticky_clr_i[i]);
      to_prev[i] = t;
      if (bus.ti_i[i]) run_m[i] = (run_m[i] + 1 > MAXC) ? MAXC : run_m[i] + 1;
      else             run_m[i] = 0;
    end
    if (bus.cfg_we_i) thr_m[bus.cfg_ch_i] = int'(bus.cfg_thr_i);
  endtask

  task automatic step();
    logic [3:0] et, ep, es;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      et[i] = m_to(i);
      ep[i] = m_to(i) & ~to_prev[i];
      es[i] = stk_m[i];
    end
    chk("model_to",     32'(bus.to_o),         32'(et));
    chk("model_pulse",  32'(bus.done_pulse_o), 32'(ep));
    chk("model_sticky", 32'(bus.sticky_o),     32'(es));
  endtask

  task automatic drive(input logic [3:0] ti, input logic [3:0] clr,
                       input logic we, input logic [1:0] ch,
                       input logic [11:0] thr);
    bus.ti_i         = ti;
    bus.sticky_clr_i = clr;
    bus.cfg_we_i     = we;
    bus.cfg_ch_i     = ch;
    bus.cfg_thr_i    = thr;
  endtask

  typedef struct {
    logic [3:0]  ti;
    logic [3:0]  clr;
    logic        we;
    logic [1:0]  ch;
    logic [11:0] thr;
    int          n;
    logic [3:0]  e_to;
    logic [3:0]  e_p;
    logic [3:0]  e_s;
  } vec_t;

  vec_t vt [17];

  initial begin
    int np;
    int first;
    tests = 0;
    fails = 0;

    vt[0]  = '{4'b0000, 4'b0000, 1'b0, 2'd0, 12'd0, 1,  4'b0000, 4'b0000, 4'b0000};
    vt[1]  = '{4'b0001, 4'b0000, 1'b0, 2'd0, 12'd0, 37, 4'b0000, 4'b0000, 4'b0000};
    vt[2]  = '{4'b0001, 4'b0000, 1'b0, 2'd0, 12'd0, 1,  4'b0001, 4'b0001, 4'b0000};
    vt[3]  = '{4'b0001, 4'b0000, 1'b0, 2'd0, 12'd0, 1,  4'b0001, 4'b0000, 4'b0001};
    vt[4]  = '{4'b0000, 4'b0000, 1'b0, 2'd0, 12'd0, 1,  4'b0000, 4'b0000, 4'b0001};
    vt[5]  = '{4'b0010, 4'b0000, 1'b0, 2'd0, 12'd0, 14, 4'b0000, 4'b0000, 4'b0001};
    vt[6]  = '{4'b0000, 4'b0000, 1'b0, 2'd0, 12'd0, 1,  4'b0000, 4'b0000, 4'b0001};
    vt[7]  = '{4'b0010, 4'b0000, 1'b0, 2'd0, 12'd0, 14, 4'b0000, 4'b0000, 4'b0001};
    vt[8]  = '{4'b0010, 4'b0000, 1'b0, 2'd0, 12'd0, 1,  4'b0010, 4'b0010, 4'b0001};
    vt[9]  = '{4'b0010, 4'b0010, 1'b0, 2'd0, 12'd0, 1,  4'b0010, 4'b0000, 4'b0011};
    vt[10] = '{4'b0010, 4'b0011, 1'b0, 2'd0, 12'd0, 1,  4'b0010, 4'b0000, 4'b0000};
    vt[11] = '{4'b0000, 4'b0000, 1'b0, 2'd0, 12'd0, 1,  4'b0000, 4'b0000, 4'b0000};
    vt[12] = '{4'b0100, 4'b0000, 1'b1, 2'd2, 12'd0, 1,  4'b0100, 4'b0100, 4'b0000};
    vt[13] = '{4'b0100, 4'b0000, 1'b1, 2'd2, 12'd5, 1,  4'b0000, 4'b0000, 4'b0100};
    vt[14] = '{4'b0100, 4'b0000, 1'b0, 2'd0, 12'd0, 2,  4'b0000, 4'b0000, 4'b0100};
    vt[15] = '{4'b0100, 4'b0000, 1'b0, 2'd0, 12'd0, 1,  4'b0100, 4'b0100, 4'b0100};
    vt[16] = '{4'b0000, 4'b0000, 1'b0, 2'd0, 12'd0, 1,  4'b0000, 4'b0000, 4'b0100};

    rst = 1'b1;
    drive(4'b0, 4'b0, 1'b0, 2'd0, 12'd0);
    bus2.ti_i         = '0;
    bus2.sticky_clr_i = '0;
    bus2.cfg_we_i     = 1'b0;
    bus2.cfg_ch_i     = '0;
    bus2.cfg_thr_i    = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_to",     32'(bus.to_o),         32'h0);
    chk("rst_pulse",  32'(bus.done_pulse_o), 32'h0);
    chk("rst_sticky", 32'(bus.sticky_o),     32'h0);
    rst = 1'b0;

    for (int v = 0; v < 17; v++) begin
      drive(vt[v].ti, vt[v].clr, vt[v].we, vt[v].ch, vt[v].thr);
      repeat (vt[v].n) step();
      chk($sformatf("vec%0d_to", v),     32'(bus.to_o),         32'(vt[v].e_to));
      chk($sformatf("vec%0d_pulse", v),  32'(bus.done_pulse_o), 32'(vt[v].e_p));
      chk($sformatf("vec%0d_sticky", v), 32'(bus.sticky_o),     32'(vt[v].e_s));
    end

    // ch3 threshold lowered then raised mid-count
    drive(4'b1000, 4'b0, 1'b0, 2'd0, 12'd0);
    repeat (100) step();
    chk("ch3_cnt100_to", 32'(bus.to_o[3]), 32'h0);
    drive(4'b1000, 4'b0, 1'b1, 2'd3, 12'd50);
    step();
    chk("ch3_lower_to",    32'(bus.to_o[3]),         32'h1);
    chk("ch3_lower_pulse", 32'(bus.done_pulse_o[3]), 32'h1);
    drive(4'b1000, 4'b0, 1'b1, 2'd3, 12'd200);
    step();
    chk("ch3_raise_to",    32'(bus.to_o[3]),         32'h0);
    chk("ch3_raise_pulse", 32'(bus.done_pulse_o[3]), 32'h0);
    drive(4'b1000, 4'b0, 1'b0, 2'd0, 12'd0);
    repeat (97) step();
    chk("ch3_cnt199_to", 32'(bus.to_o[3]), 32'h0);
    step();
    chk("ch3_cnt200_to",    32'(bus.to_o[3]),         32'h1);
    chk("ch3_cnt200_pulse", 32'(bus.done_pulse_o[3]), 32'h1);
    drive(4'b0, 4'b0, 1'b0, 2'd0, 12'd0);
    step();

    // narrow build: saturation and out-of-range channel write
    np    = 0;
    first = -1;
    bus2.ti_i = 3'b001;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (bus2.done_pulse_o[0]) np++;
      if (bus2.to_o[0] && first < 0) first = c;
    end
    chk("sat_pulses", 32'(np),              32'd1);
    chk("sat_first",  32'(first),           32'd15);
    chk("sat_to",     32'(bus2.to_o[0]),    32'h1);
    chk("sat_sticky", 32'(bus2.sticky_o[0]), 32'h1);
    bus2.ti_i      = 3'b010;
    bus2.cfg_we_i  = 1'b1;
    bus2.cfg_ch_i  = 2'd3;
    bus2.cfg_thr_i = 4'd1;
    step();
    bus2.cfg_we_i = 1'b0;
    repeat (7) step();
    chk("badch_cnt8_to", 32'(bus2.to_o[1]), 32'h0);
    step();
    chk("badch_cnt9_to", 32'(bus2.to_o[1]), 32'h1);
    bus2.ti_i = '0;

    for (int c = 0; c < 1500; c++) begin
      logic [3:0] ti;
      for (int i = 0; i < 4; i++) ti[i] = ($urandom_range(0, 9) != 0);
      drive(ti,
            ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0,
            ($urandom_range(0, 9) == 0),
            2'($urandom_range(0, 3)),
            12'($urandom_range(0, 40)));
      step();
    end

    // reset mid-count, away from the clock edge
    drive(4'b1111, 4'b0, 1'b0, 2'd0, 12'd0);
    repeat (20) step();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_to",     32'(bus.to_o),         32'h0);
    chk("async_rst_pulse",  32'(bus.done_pulse_o), 32'h0);
    chk("async_rst_sticky", 32'(bus.sticky_o),     32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (284) step();
    chk("dflt_ch3_284_to", 32'(bus.to_o[3]), 32'h0);
    step();
    chk("dflt_285_to",    32'(bus.to_o),         32'hF);
    chk("dflt_285_pulse", 32'(bus.done_pulse_o), 32'h8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
